// File: rtl/eip_seq_pkg.sv
// Shared definitions for the EIP sequencer: state encoding, legal lengths, reset vector.
package eip_seq_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StCommit = 3'd3,
        StFault  = 3'd4,
        StHalted = 3'd5
    } seq_state_e;

    localparam logic [3:0] LEN_1 = 4'd1;
    localparam logic [3:0] LEN_2 = 4'd2;
    localparam logic [3:0] LEN_4 = 4'd4;
    localparam logic [3:0] LEN_5 = 4'd5;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_000A;

    // True for the instruction lengths the decoder may legally report.
    function automatic logic is_legal_len(input logic [3:0] len);
        return (len == LEN_1) || (len == LEN_2) || (len == LEN_4) || (len == LEN_5);
    endfunction

endpackage

// File: rtl/eip_next_calc.sv
// Combinational next-EIP selection: jump > relative > sequential, modulo 2^ADDR_W.
module eip_next_calc
    import eip_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_eip,
    input  logic [3:0]        i_len,
    input  logic              i_jmp_req,
    input  logic [ADDR_W-1:0] i_jmp_target,
    input  logic              i_rel_req,
    input  logic [ADDR_W-1:0] i_rel_offset,
    output logic [ADDR_W-1:0] o_next_eip
);

    logic [ADDR_W-1:0] w_seq_eip;
    logic [ADDR_W-1:0] w_rel_eip;

    // Length is zero-extended; relative offset is taken from the sequential address.
    always_comb begin
        w_seq_eip = i_eip + {{(ADDR_W-4){1'b0}}, i_len};
        w_rel_eip = w_seq_eip + i_rel_offset;
    end

    // Priority mux; a simultaneous relative request is ignored when jumping.
    always_comb begin
        o_next_eip = w_seq_eip;
        if (i_jmp_req) begin
            o_next_eip = i_jmp_target;
        end else if (i_rel_req) begin
            o_next_eip = w_rel_eip;
        end
    end

endmodule

// File: rtl/eip_sequencer.sv
// Per-instruction EIP controller: fetch -> decode -> exec -> commit, one EIP update per instr.
module eip_sequencer
    import eip_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEFAULT)
) (
    input  logic              clock_12,
    input  logic              reset,
    input  logic              i_fetch_ready,
    input  logic              i_len_valid,
    input  logic [3:0]        i_num_of_ope,
    input  logic              i_jmp_req,
    input  logic [ADDR_W-1:0] i_jmp_target,
    input  logic              i_rel_req,
    input  logic [ADDR_W-1:0] i_rel_offset,
    input  logic              i_halt,
    output logic [ADDR_W-1:0] o_eip,
    output logic              o_fetch_valid,
    output logic              o_commit,
    output logic              o_illegal_len,
    output logic              o_halted
);

    seq_state_e        r_state;
    seq_state_e        w_state_next;
    logic [ADDR_W-1:0] r_eip;
    logic [3:0]        r_len;
    logic              r_jmp_req;
    logic [ADDR_W-1:0] r_jmp_target;
    logic              r_rel_req;
    logic [ADDR_W-1:0] r_rel_offset;
    logic              r_illegal_len;
    logic [ADDR_W-1:0] w_next_eip;
    logic              w_len_legal;

    assign w_len_legal = is_legal_len(i_num_of_ope);

    eip_next_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_calc (
        .i_eip        (r_eip),
        .i_len        (r_len),
        .i_jmp_req    (r_jmp_req),
        .i_jmp_target (r_jmp_target),
        .i_rel_req    (r_rel_req),
        .i_rel_offset (r_rel_offset),
        .o_next_eip   (w_next_eip)
    );

    // State register.
    always_ff @(posedge clock_12) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_state_next  = r_state;
        o_fetch_valid = 1'b0;
        o_commit      = 1'b0;
        o_halted      = 1'b0;
        case (r_state)
            StFetch: begin
                o_fetch_valid = 1'b1;
                if (i_fetch_ready) begin
                    w_state_next = StDecode;
                end
            end
            StDecode: begin
                if (i_len_valid) begin
                    w_state_next = w_len_legal ? StExec : StFault;
                end
            end
            StExec: begin
                w_state_next = StCommit;
            end
            StCommit: begin
                o_commit     = 1'b1;
                w_state_next = i_halt ? StHalted : StFetch;
            end
            StFault: begin
                w_state_next = StFault;
            end
            StHalted: begin
                o_halted     = 1'b1;
                w_state_next = StHalted;
            end
            default: begin
                w_state_next = StFault;
            end
        endcase
    end

    // Architectural EIP: written only by reset or in the commit cycle.
    always_ff @(posedge clock_12) begin
        if (reset) begin
            r_eip <= RESET_VECTOR;
        end else if (r_state == StCommit) begin
            r_eip <= w_next_eip;
        end
    end

    // Per-instruction operand latches, captured in DECODE and EXEC.
    always_ff @(posedge clock_12) begin
        if (reset) begin
            r_len        <= '0;
            r_jmp_req    <= 1'b0;
            r_jmp_target <= '0;
            r_rel_req    <= 1'b0;
            r_rel_offset <= '0;
        end else begin
            if (r_state == StDecode && i_len_valid) begin
                r_len <= i_num_of_ope;
            end
            if (r_state == StExec) begin
                r_jmp_req    <= i_jmp_req;
                r_jmp_target <= i_jmp_target;
                r_rel_req    <= i_rel_req;
                r_rel_offset <= i_rel_offset;
            end
        end
    end

    // Sticky illegal-length flag, set on the transition into FAULT.
    always_ff @(posedge clock_12) begin
        if (reset) begin
            r_illegal_len <= 1'b0;
        end else if (r_state == StDecode && i_len_valid && !w_len_legal) begin
            r_illegal_len <= 1'b1;
        end
    end

    assign o_eip         = r_eip;
    assign o_illegal_len = r_illegal_len;

endmodule

// File: tb/tb_eip_sequencer.sv
// Self-checking bench for eip_sequencer: table-driven instructions plus corner sequences.
module tb_eip_sequencer;

    localparam int unsigned ADDR_W = 32;

    logic              clock_12;
    logic              reset;
    logic              i_fetch_ready;
    logic              i_len_valid;
    logic [3:0]        i_num_of_ope;
    logic              i_jmp_req;
    logic [ADDR_W-1:0] i_jmp_target;
    logic              i_rel_req;
    logic [ADDR_W-1:0] i_rel_offset;
    logic              i_halt;
    logic [ADDR_W-1:0] o_eip;
    logic              o_fetch_valid;
    logic              o_commit;
    logic              o_illegal_len;
    logic              o_halted;

    int n_tests;
    int n_fail;

    eip_sequencer #(
        .ADDR_W       (ADDR_W),
        .RESET_VECTOR (32'h0000_000A)
    ) dut (
        .clock_12      (clock_12),
        .reset         (reset),
        .i_fetch_ready (i_fetch_ready),
        .i_len_valid   (i_len_valid),
        .i_num_of_ope  (i_num_of_ope),
        .i_jmp_req     (i_jmp_req),
        .i_jmp_target  (i_jmp_target),
        .i_rel_req     (i_rel_req),
        .i_rel_offset  (i_rel_offset),
        .i_halt        (i_halt),
        .o_eip         (o_eip),
        .o_fetch_valid (o_fetch_valid),
        .o_commit      (o_commit),
        .o_illegal_len (o_illegal_len),
        .o_halted      (o_halted)
    );

    initial clock_12 = 1'b0;
    always #5 clock_12 = ~clock_12;

    typedef struct {
        logic [3:0]  len;
        logic        jmp;
        logic [31:0] tgt;
        logic        rel;
        logic [31:0] off;
        logic [31:0] exp_eip;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs one instruction with inputs held; starts and ends at a negedge.
    task automatic run_instr(input string name, input logic [3:0] len, input logic jmp,
                             input logic [31:0] tgt, input logic rel, input logic [31:0] off,
                             input logic hlt, input logic [31:0] exp_eip);
        int lat;
        int commits;
        check({name, " fetch_valid"}, 32'(o_fetch_valid), 32'd1);
        i_fetch_ready = 1'b1;
        i_len_valid   = 1'b1;
        i_num_of_ope  = len;
        i_jmp_req     = jmp;
        i_jmp_target  = tgt;
        i_rel_req     = rel;
        i_rel_offset  = off;
        i_halt        = hlt;
        lat     = 0;
        commits = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock_12);
            if (o_commit) begin
                commits++;
                lat = i;
                break;
            end
        end
        check({name, " latency"}, 32'(lat), 32'd3);
        @(negedge clock_12);
        if (o_commit) commits++;
        check({name, " commits"}, 32'(commits), 32'd1);
        check({name, " eip"}, o_eip, exp_eip);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock_12);
        @(negedge clock_12);
        reset = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset         = 1'b1;
        i_fetch_ready = 1'b0;
        i_len_valid   = 1'b0;
        i_num_of_ope  = 4'd0;
        i_jmp_req     = 1'b0;
        i_jmp_target  = '0;
        i_rel_req     = 1'b0;
        i_rel_offset  = '0;
        i_halt        = 1'b0;

        vecs[0] = '{4'd1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0000_000B};
        vecs[1] = '{4'd2, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0000_000D};
        vecs[2] = '{4'd4, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0000_0011};
        vecs[3] = '{4'd5, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0000_0016};
        vecs[4] = '{4'd1, 1'b1, 32'h20,         1'b0, 32'h0,          32'h0000_0020};
        vecs[5] = '{4'd2, 1'b1, 32'h100,        1'b1, 32'h10,         32'h0000_0100};
        vecs[6] = '{4'd1, 1'b1, 32'h30,         1'b0, 32'h0,          32'h0000_0030};
        vecs[7] = '{4'd5, 1'b0, 32'h0,          1'b1, 32'hFFFF_FFFC,  32'h0000_0031};
        vecs[8] = '{4'd2, 1'b1, 32'hFFFF_FFFE,  1'b0, 32'h0,          32'hFFFF_FFFE};
        vecs[9] = '{4'd4, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0000_0002};

        do_reset();
        check("reset eip", o_eip, 32'h0000_000A);
        check("reset commit", 32'(o_commit), 32'd0);
        check("reset illegal", 32'(o_illegal_len), 32'd0);
        check("reset halted", 32'(o_halted), 32'd0);
        check("reset fetch_valid", 32'(o_fetch_valid), 32'd1);

        // FETCH holds while fetch_ready is low.
        repeat (3) @(negedge clock_12);
        check("fetch hold", 32'(o_fetch_valid), 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_instr($sformatf("vec%0d", i), vecs[i].len, vecs[i].jmp, vecs[i].tgt,
                      vecs[i].rel, vecs[i].off, 1'b0, vecs[i].exp_eip);
        end
        check("wrap no fault", 32'(o_illegal_len), 32'd0);

        // Halt in COMMIT: eip still updates, then the sequencer parks.
        run_instr("halt", 4'd1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0003);
        check("halt halted", 32'(o_halted), 32'd1);
        check("halt fetch_valid", 32'(o_fetch_valid), 32'd0);
        repeat (4) @(negedge clock_12);
        check("halt eip hold", o_eip, 32'h0000_0003);
        check("halt commit", 32'(o_commit), 32'd0);
        check("halt stays", 32'(o_halted), 32'd1);

        // Illegal length 3 enters FAULT with eip frozen.
        i_halt = 1'b0;
        do_reset();
        i_num_of_ope = 4'd3;
        repeat (2) @(negedge clock_12);
        check("illegal flag", 32'(o_illegal_len), 32'd1);
        check("illegal eip", o_eip, 32'h0000_000A);
        check("illegal fetch_valid", 32'(o_fetch_valid), 32'd0);
        i_num_of_ope = 4'd1;
        repeat (5) @(negedge clock_12);
        check("fault commit", 32'(o_commit), 32'd0);
        check("fault sticky", 32'(o_illegal_len), 32'd1);
        check("fault eip", o_eip, 32'h0000_000A);
        reset = 1'b1;
        @(negedge clock_12);
        reset = 1'b0;
        check("fault reset eip", o_eip, 32'h0000_000A);
        check("fault reset flag", 32'(o_illegal_len), 32'd0);

        // Advance eip, then reset while waiting in DECODE.
        run_instr("pre", 4'd4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0000_000E);
        i_len_valid = 1'b0;
        @(negedge clock_12);
        check("decode wait", 32'(o_fetch_valid), 32'd0);
        reset = 1'b1;
        @(negedge clock_12);
        reset = 1'b0;
        check("rst decode fetch_valid", 32'(o_fetch_valid), 32'd1);
        check("rst decode eip", o_eip, 32'h0000_000A);
        check("rst decode commit", 32'(o_commit), 32'd0);

        // Reset during the COMMIT cycle must not let the update through.
        i_len_valid  = 1'b1;
        i_num_of_ope = 4'd2;
        repeat (3) @(negedge clock_12);
        check("pre-rst commit", 32'(o_commit), 32'd1);
        reset = 1'b1;
        @(negedge clock_12);
        reset = 1'b0;
        check("rst commit eip", o_eip, 32'h0000_000A);
        check("rst commit pulse", 32'(o_commit), 32'd0);

        // Stale latched target must not leak after reset: plain sequential step.
        run_instr("post", 4'd1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0000_000B);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
